// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code parser: turns make/break/extended byte sequences into
// single-cycle key events and tracks shift and caps-lock state.
module ps2_key_decoder (
  input  logic       pixel_clk_in,
  input  logic       rst_in,
  input  logic [7:0] scan_code_in,
  input  logic       scan_valid_in,
  output logic [7:0] char_out,
  output logic       char_valid_out,
  output logic       enter_out,
  output logic       bksp_out,
  output logic       scroll_up_out,
  output logic       scroll_down_out,
  output logic       shift_out,
  output logic       caps_out
);

  localparam logic [7:0] CODE_BRK    = 8'hF0;
  localparam logic [7:0] CODE_EXT    = 8'hE0;
  localparam logic [7:0] CODE_LSHIFT = 8'h12;
  localparam logic [7:0] CODE_RSHIFT = 8'h59;
  localparam logic [7:0] CODE_CAPS   = 8'h58;
  localparam logic [7:0] CODE_ENTER  = 8'h5A;
  localparam logic [7:0] CODE_BKSP   = 8'h66;
  localparam logic [7:0] CODE_UP     = 8'h75;
  localparam logic [7:0] CODE_DOWN   = 8'h72;

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  state_t     state;
  logic       lshift_held;
  logic       rshift_held;
  logic       caps_held;
  logic [8:0] dec_c;

  // Returns {hit, ascii}; letters follow shift^caps, everything else shift only.
  function automatic logic [8:0] decode_make(input logic [7:0] code,
                                             input logic shift,
                                             input logic caps);
    logic       hit;
    logic       letter;
    logic [7:0] lo;
    logic [7:0] hi;
    hit    = 1'b1;
    letter = 1'b0;
    lo     = 8'h00;
    hi     = 8'h00;
    case (code)
      8'h1C: {letter, lo, hi} = {1'b1, "a", "A"};
      8'h32: {letter, lo, hi} = {1'b1, "b", "B"};
      8'h21: {letter, lo, hi} = {1'b1, "c", "C"};
      8'h23: {letter, lo, hi} = {1'b1, "d", "D"};
      8'h24: {letter, lo, hi} = {1'b1, "e", "E"};
      8'h2B: {letter, lo, hi} = {1'b1, "f", "F"};
      8'h34: {letter, lo, hi} = {1'b1, "g", "G"};
      8'h33: {letter, lo, hi} = {1'b1, "h", "H"};
      8'h43: {letter, lo, hi} = {1'b1, "i", "I"};
      8'h3B: {letter, lo, hi} = {1'b1, "j", "J"};
      8'h42: {letter, lo, hi} = {1'b1, "k", "K"};
      8'h4B: {letter, lo, hi} = {1'b1, "l", "L"};
      8'h3A: {letter, lo, hi} = {1'b1, "m", "M"};
      8'h31: {letter, lo, hi} = {1'b1, "n", "N"};
      8'h44: {letter, lo, hi} = {1'b1, "o", "O"};
      8'h4D: {letter, lo, hi} = {1'b1, "p", "P"};
      8'h15: {letter, lo, hi} = {1'b1, "q", "Q"};
      8'h2D: {letter, lo, hi} = {1'b1, "r", "R"};
      8'h1B: {letter, lo, hi} = {1'b1, "s", "S"};
      8'h2C: {letter, lo, hi} = {1'b1, "t", "T"};
      8'h3C: {letter, lo, hi} = {1'b1, "u", "U"};
      8'h2A: {letter, lo, hi} = {1'b1, "v", "V"};
      8'h1D: {letter, lo, hi} = {1'b1, "w", "W"};
      8'h22: {letter, lo, hi} = {1'b1, "x", "X"};
      8'h35: {letter, lo, hi} = {1'b1, "y", "Y"};
      8'h1A: {letter, lo, hi} = {1'b1, "z", "Z"};
      8'h45: {lo, hi} = {"0", ")"};
      8'h16: {lo, hi} = {"1", "!"};
      8'h1E: {lo, hi} = {"2", "@"};
      8'h26: {lo, hi} = {"3", "#"};
      8'h25: {lo, hi} = {"4", "$"};
      8'h2E: {lo, hi} = {"5", "%"};
      8'h36: {lo, hi} = {"6", "^"};
      8'h3D: {lo, hi} = {"7", "&"};
      8'h3E: {lo, hi} = {"8", "*"};
      8'h46: {lo, hi} = {"9", "("};
      8'h29: {lo, hi} = {" ", " "};
      8'h41: {lo, hi} = {",", "<"};
      8'h49: {lo, hi} = {".", ">"};
      8'h4E: {lo, hi} = {"-", "_"};
      8'h55: {lo, hi} = {"=", "+"};
      8'h4C: {lo, hi} = {";", ":"};
      8'h4A: {lo, hi} = {"/", "?"};
      8'h52: {lo, hi} = {"'", "\""};
      default: hit = 1'b0;
    endcase
    if (letter ? (shift ^ caps) : shift) begin
      return {hit, hi};
    end
    return {hit, lo};
  endfunction

  // Lookup always sees the modifier state from before the current byte.
  assign dec_c = decode_make(scan_code_in, shift_out, caps_out);

  // Parser FSM, modifier tracking and registered event outputs.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state           <= IDLE;
      lshift_held     <= 1'b0;
      rshift_held     <= 1'b0;
      caps_held       <= 1'b0;
      shift_out       <= 1'b0;
      caps_out        <= 1'b0;
      char_out        <= 8'h00;
      char_valid_out  <= 1'b0;
      enter_out       <= 1'b0;
      bksp_out        <= 1'b0;
      scroll_up_out   <= 1'b0;
      scroll_down_out <= 1'b0;
    end else begin
      char_valid_out  <= 1'b0;
      enter_out       <= 1'b0;
      bksp_out        <= 1'b0;
      scroll_up_out   <= 1'b0;
      scroll_down_out <= 1'b0;
      if (scan_valid_in) begin
        case (state)
          IDLE: begin
            if (scan_code_in == CODE_BRK) begin
              state <= BRK;
            end else if (scan_code_in == CODE_EXT) begin
              state <= EXT;
            end else begin
              case (scan_code_in)
                8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: ;
                CODE_LSHIFT: begin
                  lshift_held <= 1'b1;
                  shift_out   <= 1'b1;
                end
                CODE_RSHIFT: begin
                  rshift_held <= 1'b1;
                  shift_out   <= 1'b1;
                end
                CODE_CAPS: begin
                  // Typematic repeats of caps lock must not re-toggle.
                  if (!caps_held) caps_out <= ~caps_out;
                  caps_held <= 1'b1;
                end
                CODE_ENTER: enter_out <= 1'b1;
                CODE_BKSP:  bksp_out  <= 1'b1;
                default: begin
                  if (dec_c[8]) begin
                    char_out       <= dec_c[7:0];
                    char_valid_out <= 1'b1;
                  end
                end
              endcase
            end
          end
          BRK: begin
            if (scan_code_in == CODE_EXT) begin
              state <= EXT_BRK;
            end else if (scan_code_in != CODE_BRK) begin
              state <= IDLE;
              case (scan_code_in)
                CODE_LSHIFT: begin
                  lshift_held <= 1'b0;
                  shift_out   <= rshift_held;
                end
                CODE_RSHIFT: begin
                  rshift_held <= 1'b0;
                  shift_out   <= lshift_held;
                end
                CODE_CAPS: caps_held <= 1'b0;
                default: ;
              endcase
            end
          end
          EXT: begin
            if (scan_code_in == CODE_BRK) begin
              state <= EXT_BRK;
            end else begin
              // Fake shifts (E0 12 / E0 59) land here and are ignored.
              state <= IDLE;
              if (scan_code_in == CODE_UP)   scroll_up_out   <= 1'b1;
              if (scan_code_in == CODE_DOWN) scroll_down_out <= 1'b1;
            end
          end
          EXT_BRK: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed test-plan steps followed by
// random byte streams, all compared against a sequence-level reference model.
module tb_ps2_key_decoder;

  logic       clk;
  logic       rst;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic [7:0] char_out;
  logic       char_valid;
  logic       enter;
  logic       bksp;
  logic       scroll_up;
  logic       scroll_down;
  logic       shift;
  logic       caps;

  int vectors;
  int miscompares;

  ps2_key_decoder dut (
    .pixel_clk_in    (clk),
    .rst_in          (rst),
    .scan_code_in    (scan_code),
    .scan_valid_in   (scan_valid),
    .char_out        (char_out),
    .char_valid_out  (char_valid),
    .enter_out       (enter),
    .bksp_out        (bksp),
    .scroll_up_out   (scroll_up),
    .scroll_down_out (scroll_down),
    .shift_out       (shift),
    .caps_out        (caps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key tables straight from the scan-code map.
  string      letters = "abcdefghijklmnopqrstuvwxyz";
  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  string      sym_lo = "0123456789 ,.-=;/'";
  string      sym_hi = ")!@#$%^&*( <>_+:?\"";
  logic [7:0] sym_codes [18] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
    8'h3D, 8'h3E, 8'h46, 8'h29, 8'h41, 8'h49, 8'h4E, 8'h55, 8'h4C, 8'h4A, 8'h52};

  // Reference model state: pending prefix bytes plus key/modifier state.
  bit         m_pend_e, m_pend_f;
  bit         m_lshift, m_rshift, m_caps_held, m_caps;
  logic [7:0] m_char;
  bit         e_char, e_enter, e_bksp, e_up, e_down;

  task automatic model_reset();
    m_pend_e = 0; m_pend_f = 0;
    m_lshift = 0; m_rshift = 0; m_caps_held = 0; m_caps = 0;
    m_char = 8'h00;
    e_char = 0; e_enter = 0; e_bksp = 0; e_up = 0; e_down = 0;
  endtask

  task automatic model_make(input logic [7:0] b);
    bit sh;
    sh = m_lshift | m_rshift;
    if (b == 8'h12) m_lshift = 1;
    else if (b == 8'h59) m_rshift = 1;
    else if (b == 8'h58) begin
      if (!m_caps_held) m_caps = !m_caps;
      m_caps_held = 1;
    end else if (b == 8'h5A) e_enter = 1;
    else if (b == 8'h66) e_bksp = 1;
    else begin
      for (int i = 0; i < 26; i++)
        if (letter_codes[i] == b) begin
          m_char = (sh ^ m_caps) ? 8'(letters[i] - 8'd32) : letters[i];
          e_char = 1;
        end
      for (int i = 0; i < 18; i++)
        if (sym_codes[i] == b) begin
          m_char = sh ? sym_hi[i] : sym_lo[i];
          e_char = 1;
        end
    end
  endtask

  task automatic model_byte(input bit v, input logic [7:0] b);
    e_char = 0; e_enter = 0; e_bksp = 0; e_up = 0; e_down = 0;
    if (!v) return;
    if (!m_pend_e && !m_pend_f) begin
      if (b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF}) ;
      else if (b == 8'hF0) m_pend_f = 1;
      else if (b == 8'hE0) m_pend_e = 1;
      else model_make(b);
    end else if (m_pend_f && !m_pend_e) begin
      if (b == 8'hE0) m_pend_e = 1;
      else if (b != 8'hF0) begin
        m_pend_f = 0;
        if (b == 8'h12) m_lshift = 0;
        if (b == 8'h59) m_rshift = 0;
        if (b == 8'h58) m_caps_held = 0;
      end
    end else if (m_pend_e && !m_pend_f) begin
      if (b == 8'hF0) m_pend_f = 1;
      else begin
        m_pend_e = 0;
        e_up   = (b == 8'h75);
        e_down = (b == 8'h72);
      end
    end else begin
      m_pend_e = 0; m_pend_f = 0;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("char_out", char_out, m_char);
    check("char_valid", 8'(char_valid), 8'(e_char));
    check("enter", 8'(enter), 8'(e_enter));
    check("bksp", 8'(bksp), 8'(e_bksp));
    check("scroll_up", 8'(scroll_up), 8'(e_up));
    check("scroll_down", 8'(scroll_down), 8'(e_down));
    check("shift", 8'(shift), 8'(m_lshift | m_rshift));
    check("caps", 8'(caps), 8'(m_caps));
    check("onehot0", 8'($onehot0({char_valid, enter, bksp, scroll_up, scroll_down})), 8'd1);
  endtask

  // Apply one cycle of input, then check the registered response.
  task automatic cyc(input bit v, input logic [7:0] b);
    scan_valid = v;
    scan_code  = b;
    @(posedge clk);
    #1;
    model_byte(v, b);
    check_all();
  endtask

  logic [7:0] pool [20] = '{8'h1C, 8'h32, 8'h1A, 8'h16, 8'h45, 8'h29, 8'h41, 8'h52,
    8'h12, 8'h59, 8'h58, 8'hF0, 8'hE0, 8'h5A, 8'h66, 8'h75, 8'h72, 8'hAA, 8'h0E, 8'h4E};

  initial begin
    logic [7:0] b;
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    scan_valid = 1'b0;
    scan_code = 8'h00;
    model_reset();
    #2;
    check_all();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // 1C, F0 1C -> 'a', silent break
    cyc(1, 8'h1C); check("plan_a", char_out, 8'h61); check("plan_a_v", 8'(char_valid), 8'd1);
    cyc(1, 8'hF0); cyc(1, 8'h1C); check("plan_brk_quiet", 8'(char_valid), 8'd0);
    cyc(0, 8'h00);

    // shift/caps interplay
    cyc(1, 8'h12); check("plan_shift1", 8'(shift), 8'd1);
    cyc(1, 8'h1C); check("plan_A", char_out, 8'h41);
    cyc(1, 8'hF0); cyc(1, 8'h12); check("plan_shift0", 8'(shift), 8'd0);
    cyc(1, 8'h1C); check("plan_a2", char_out, 8'h61);
    cyc(1, 8'h58); cyc(1, 8'hF0); cyc(1, 8'h58); check("plan_caps1", 8'(caps), 8'd1);
    cyc(1, 8'h16); check("plan_1", char_out, 8'h31);
    cyc(1, 8'h12); cyc(1, 8'h16); check("plan_bang", char_out, 8'h21);
    cyc(1, 8'h1C); check("plan_shift_caps_a", char_out, 8'h61);
    cyc(1, 8'hF0); cyc(1, 8'h12);

    // caps typematic: one toggle per press
    for (int r = 0; r < 2; r++) begin
      cyc(1, 8'h58); cyc(1, 8'h58); cyc(1, 8'h58); cyc(1, 8'hF0); cyc(1, 8'h58);
    end
    check("plan_caps_twice", 8'(caps), 8'd1);
    cyc(1, 8'h58); cyc(1, 8'h58); cyc(1, 8'hF0); cyc(1, 8'h58);
    check("plan_caps_off", 8'(caps), 8'd0);

    // extended keys and fake shift
    cyc(1, 8'hE0); cyc(1, 8'h75); check("plan_up", 8'(scroll_up), 8'd1);
    cyc(1, 8'hE0); cyc(1, 8'hF0); cyc(1, 8'h75); check("plan_up_brk", 8'(scroll_up), 8'd0);
    cyc(1, 8'hE0); cyc(1, 8'h72); check("plan_down", 8'(scroll_down), 8'd1);
    cyc(1, 8'hE0); cyc(1, 8'h12); check("plan_fake_shift", 8'(shift), 8'd0);

    // enter, backspace, unmapped, ack
    cyc(1, 8'h5A); check("plan_enter", 8'(enter), 8'd1);
    cyc(1, 8'h66); check("plan_bksp", 8'(bksp), 8'd1); check("plan_enter_1cyc", 8'(enter), 8'd0);
    cyc(1, 8'h0E); cyc(1, 8'hAA); check("plan_char_hold", char_out, 8'h61);
    cyc(0, 8'h00);

    // reset between prefix and code byte
    cyc(1, 8'hE0);
    scan_valid = 1'b0;
    rst = 1'b1;
    #2;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1, 8'h1C); check("plan_rst_mid", char_out, 8'h61);
    cyc(1, 8'h12); cyc(1, 8'h1C); check("plan_b2b_A", char_out, 8'h41);
    cyc(1, 8'hF0); cyc(1, 8'h12);

    // random byte stream against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) b = 8'($urandom);
      else b = pool[$urandom_range(0, 19)];
      cyc($urandom_range(0, 9) < 7, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Converts the raw PS/2 set-2 scan-code byte stream from the keyboard receiver into single-cycle key events: printable ASCII characters, enter, backspace, and scroll up/down. It sits between the PS/2 receiver and `terminal_controller`. It absorbs the break-code filtering and key-type tracking currently done inline in the top level, and adds shift, caps-lock and extended-key handling.

## Interface
Parameters: none. The scan-code map is fixed.

Ports:
- `pixel_clk_in`  in  1  system clock (74.25 MHz pixel clock)
- `rst_in`  in  1  asynchronous, active-high reset
- `scan_code_in`  in  8  received scan-code byte
- `scan_valid_in`  in  1  one-cycle strobe; `scan_code_in` is valid this cycle
- `char_out`  out  8  ASCII of the last printable key; held until the next printable key
- `char_valid_out`  out  1  one-cycle strobe; new printable key on `char_out`
- `enter_out`  out  1  one-cycle strobe, Enter (5A) make
- `bksp_out`  out  1  one-cycle strobe, Backspace (66) make
- `scroll_up_out`  out  1  one-cycle strobe, E0 75 make
- `scroll_down_out`  out  1  one-cycle strobe, E0 72 make
- `shift_out`  out  1  level; either shift key held
- `caps_out`  out  1  level; caps-lock state

## Operation
- **Parser FSM states:** IDLE, BRK, EXT, EXT_BRK. All transitions occur only on `scan_valid_in`.
- **IDLE transitions:**
  - F0 -> BRK
  - E0 -> EXT
  - AA, FA, FE, EE, 00, FF -> stay in IDLE, no effect
  - any other byte = make code: process it, stay in IDLE
- **BRK:** any byte except E0/F0 = break code -> process release, go to IDLE. Repeated F0 stays in BRK. E0 goes to EXT_BRK.
- **EXT:** F0 -> EXT_BRK. Any other byte = extended make -> process it, go to IDLE.
- **EXT_BRK:** any byte = extended break -> IDLE. It has no effect; extended keys carry no held state.
- **Extended makes:**
  - 75 -> `scroll_up_out`
  - 72 -> `scroll_down_out`
  - all others ignored, including E0 12 and E0 59 (fake shift), which must not touch shift state
- **Modifiers:**
  - Left shift is 12, right shift is 59; each has its own held flag, set on make and cleared on break.
  - `shift_out` is the OR of the two flags.
  - Caps lock (58) toggles `caps_out` on make only if its held flag is clear, then sets that flag. The flag clears on break, so typematic repeat does not re-toggle.
- **Make code map:**
  - Letters: 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z.
  - Letter case: upper case when shift XOR caps is true.
  - Digits: 45 0, 16 1, 1E 2, 26 3, 25 4, 2E 5, 36 6, 3D 7, 3E 8, 46 9.
  - Digits with shift (caps has no effect): `) ! @ # $ % ^ & * (` respectively.
  - Space: 29.
  - Punctuation, unshifted/shifted: 41 `,`/`<`, 49 `.`/`>`, 4E `-`/`_`, 55 `=`/`+`, 4C `;`/`:`, 4A `/`/`?`, 52 `'`/`"`.
  - Enter 5A and backspace 66 produce their strobes; `char_out` is unchanged.
  - Unmapped makes are ignored.
- **Typematic repeat:** a repeated make of a held key emits a new event each time. This is intended.
- **Mutual exclusion:** at most one of `char_valid_out`, `enter_out`, `bksp_out`, `scroll_up_out`, `scroll_down_out` is high in any cycle.

## Timing
- **Reset values (async, immediate):**
  - FSM in IDLE
  - all held flags 0, `caps_out` 0, `shift_out` 0
  - `char_out` 8'h00
  - all strobes 0
- **Latency:** event strobes and `char_out` are registered. They assert in the cycle after the `scan_valid_in` that completes the sequence, and last exactly one cycle.
- **Modifier latency:** `shift_out` and `caps_out` update one cycle after the completing byte.
- **Modifier use:** case and shift selection use the modifier state from before the current byte. A shift make and a letter make in back-to-back cycles must still shift the letter.
- **Throughput:** `scan_valid_in` may assert every cycle; no byte is dropped and there is no backpressure.
- **Reset mid-sequence:** a reset between a prefix and the code byte returns to IDLE; the following byte is treated as a make.

## Test plan
- Reset, then bytes 1C, F0, 1C -> one `char_valid_out` with `char_out`=8'h61 ('a'); no strobe on the break; FSM back in IDLE.
- 12, 1C, F0 12, 1C -> chars 'A' (8'h41) then 'a' (8'h61); `shift_out` 1 then 0. Then 58, F0 58, 16 -> `caps_out`=1, char '1' (8'h31); then 12, 16 -> '!' (8'h21).
- 58, 58, 58 (typematic), F0 58 -> `caps_out` toggles once to 1. Repeat the sequence -> `caps_out`=0.
- E0 75, E0 F0 75, E0 72, E0 12 -> one `scroll_up_out`, one `scroll_down_out`; `shift_out` stays 0 throughout; no `char_valid_out`.
- 5A, 66, 0E (unmapped), AA -> `enter_out` then `bksp_out`, each one cycle wide, one cycle after its byte; `char_out` unchanged; nothing for 0E or AA.
- Assert `rst_in` after an E0 byte, then release and send 1C -> `char_out`=8'h61 with `char_valid_out`. Also drive bytes on consecutive cycles (12, 1C) -> 'A' emitted.
